// File: rtl/fp_regfile_if.sv
// fp_regfile_if: read/write port bundle between the FP pipeline and the FP register file
interface fp_regfile_if #(
  parameter int SCALE = 5,
  parameter int WIDTH = 32
);
  logic [SCALE-1:0] ra0;
  logic [WIDTH-1:0] rd0;
  logic [SCALE-1:0] ra1;
  logic [WIDTH-1:0] rd1;
  logic [SCALE-1:0] wa;
  logic             we;
  logic [WIDTH-1:0] wd;
  modport master (output ra0, ra1, wa, we, wd, input rd0, rd1);
  modport slave  (input ra0, ra1, wa, we, wd, output rd0, rd1);
endinterface

// File: rtl/fp_regfile.sv
// fp_regfile: 2**SCALE x WIDTH FP register file, 2 comb reads, 1 sync write; FREG_BYPASS_EN adds write-to-read forwarding
module fp_regfile #(
  parameter int SCALE = 5,
  parameter int WIDTH = 32
) (
  input logic         clk,
  input logic         rst,
  fp_regfile_if.slave bus
);
  logic [WIDTH-1:0] mem [2**SCALE];
  always_ff @(posedge clk)
    if (rst) for (int i = 0; i < 2**SCALE; i++) mem[i] <= '0;
    else if (bus.we) mem[bus.wa] <= bus.wd;
`ifdef FREG_BYPASS_EN
  logic fwd0, fwd1;
  assign fwd0 = bus.we && !rst && bus.ra0 == bus.wa;
  assign fwd1 = bus.we && !rst && bus.ra1 == bus.wa;
  assign bus.rd0 = fwd0 ? bus.wd : mem[bus.ra0];
  assign bus.rd1 = fwd1 ? bus.wd : mem[bus.ra1];
`else
  assign bus.rd0 = mem[bus.ra0];
  assign bus.rd1 = mem[bus.ra1];
`endif
endmodule

// File: tb/tb_fp_regfile.sv
// tb_fp_regfile: directed self-checking bench for fp_regfile
module tb_fp_regfile;
  logic clk = 0;
  logic rst;
  int n_checks = 0;
  int n_fail = 0;
  logic [31:0] instr;
  fp_regfile_if #(.SCALE(5), .WIDTH(32)) bus ();
  fp_regfile #(.SCALE(5), .WIDTH(32)) dut (.clk(clk), .rst(rst), .bus(bus));
  always #5 clk = ~clk;
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask
  task automatic wr(input logic [4:0] a, input logic [31:0] d);
    bus.we = 1;
    bus.wa = a;
    bus.wd = d;
    @(posedge clk);
    #1;
    bus.we = 0;
  endtask
  function automatic logic [31:0] pat(input int i);
    logic [15:0] v;
    v = i[15:0];
    return {v, ~v};
  endfunction
  initial begin
    rst = 1;
    bus.we = 0;
    bus.wa = 0;
    bus.wd = 0;
    bus.ra0 = 0;
    bus.ra1 = 0;
    repeat (2) @(posedge clk);
    #1;
    rst = 0;
    bus.ra0 = 0;
    bus.ra1 = 31;
    #1;
    check("reset_state_e0", bus.rd0, 32'h0);
    check("reset_state_e31", bus.rd1, 32'h0);
    // reset with a colliding write, plus latency check before the edge
    wr(1, 32'h11111111);
    wr(2, 32'h22222222);
    wr(4, 32'h44444444);
    rst = 1;
    bus.we = 1;
    bus.wa = 3;
    bus.wd = 32'hDEADBEEF;
    bus.ra0 = 1;
    bus.ra1 = 4;
    #1;
    check("reset_latency_e1", bus.rd0, 32'h11111111);
    check("reset_latency_e4", bus.rd1, 32'h44444444);
    @(posedge clk);
    #1;
    rst = 0;
    bus.we = 0;
    bus.ra0 = 1;
    bus.ra1 = 2;
    #1;
    check("reset_clr_e1", bus.rd0, 32'h0);
    check("reset_clr_e2", bus.rd1, 32'h0);
    bus.ra0 = 3;
    bus.ra1 = 4;
    #1;
    check("reset_drops_write", bus.rd0, 32'h0);
    check("reset_clr_e4", bus.rd1, 32'h0);
    // basic write/read, addresses from instruction fields
    wr(1, 32'h3F800000);
    wr(2, 32'h40000000);
    instr = 32'h0020f253;
    bus.ra0 = instr[19:15];
    bus.ra1 = instr[24:20];
    #1;
    check("basic_rs1", bus.rd0, 32'h3F800000);
    check("basic_rs2", bus.rd1, 32'h40000000);
    // entry 0 is a real register
    wr(4, 32'h40400000);
    wr(0, 32'h12345678);
    instr = 32'h00402027;
    bus.ra0 = instr[19:15];
    bus.ra1 = instr[24:20];
    #1;
    check("entry0_write", bus.rd0, 32'h12345678);
    check("entry0_rs2_e4", bus.rd1, 32'h40400000);
    // write enable gating
    bus.we = 0;
    bus.wa = 5;
    bus.wd = 32'hFFFFFFFF;
    repeat (3) @(posedge clk);
    #1;
    bus.wa = 'x;
    bus.wd = 'x;
    @(posedge clk);
    #1;
    bus.ra0 = 5;
    bus.ra1 = 0;
    #1;
    check("we_gate_e5", bus.rd0, 32'h0);
    check("we_gate_xsafe_e0", bus.rd1, 32'h12345678);
    // read during write
    wr(6, 32'hAAAAAAAA);
    bus.ra0 = 6;
    bus.ra1 = 6;
    bus.we = 1;
    bus.wa = 6;
    bus.wd = 32'h55555555;
    #1;
`ifdef FREG_BYPASS_EN
    check("rdw_pre_rd0", bus.rd0, 32'h55555555);
    check("rdw_pre_rd1", bus.rd1, 32'h55555555);
`else
    check("rdw_pre_rd0", bus.rd0, 32'hAAAAAAAA);
    check("rdw_pre_rd1", bus.rd1, 32'hAAAAAAAA);
`endif
    @(posedge clk);
    #1;
    bus.we = 0;
    #1;
    check("rdw_post_rd0", bus.rd0, 32'h55555555);
    check("rdw_post_rd1", bus.rd1, 32'h55555555);
    // full sweep, then reset clears everything
    for (int i = 0; i < 32; i++) wr(i[4:0], pat(i));
    for (int i = 0; i < 32; i++) begin
      bus.ra0 = i[4:0];
      bus.ra1 = 5'(31 - i);
      #1;
      check($sformatf("sweep_rd0_%0d", i), bus.rd0, pat(i));
      check($sformatf("sweep_rd1_%0d", 31 - i), bus.rd1, pat(31 - i));
    end
    rst = 1;
    @(posedge clk);
    #1;
    rst = 0;
    for (int i = 0; i < 32; i++) begin
      bus.ra0 = i[4:0];
      bus.ra1 = 5'(31 - i);
      #1;
      check($sformatf("sweep_clr_rd0_%0d", i), bus.rd0, 32'h0);
      check($sformatf("sweep_clr_rd1_%0d", 31 - i), bus.rd1, 32'h0);
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
